reset_supervisor: RTL and testbench



---
 rtl/reset_supervisor.sv | 151 +++++++++++++++
 tb/tb_reset_supervisor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reset_supervisor.sv
// Reset and fault supervisor: stretches and synchronises the button reset
// into the system, watches trap and a software watchdog, and halts or
// restarts the system on a fault while reporting status.
module reset_supervisor #(
   parameter int RESET_CYCLES = 16,
   parameter int WDT_CYCLES   = 2000000,
   parameter int TRAP_HOLD    = 1000000,
   parameter int AUTORESTART  = 1,
   parameter int BLINK_CYCLES = 250000
) (
   input  logic       clk,
   input  logic       power_on_reset,
   input  logic       trap,
   input  logic       wdt_kick,
   output logic       sys_reset,
   output logic       halted,
   output logic       status_led,
   output logic [7:0] trap_count,
   output logic [1:0] last_cause
);

   localparam int RW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int WW = (WDT_CYCLES   > 1) ? $clog2(WDT_CYCLES)   : 1;
   localparam int HW = (TRAP_HOLD    > 1) ? $clog2(TRAP_HOLD)    : 1;
   localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

   localparam logic [RW-1:0] RST_LAST   = RW'(RESET_CYCLES - 1);
   localparam logic [WW-1:0] WDT_LAST   = WW'(WDT_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST  = HW'(TRAP_HOLD - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);
   localparam bit            WDT_EN     = (WDT_CYCLES != 0);
   localparam bit            AUTO_EN    = (AUTORESTART != 0);

   localparam logic [1:0] CAUSE_POR  = 2'b01;
   localparam logic [1:0] CAUSE_TRAP = 2'b10;
   localparam logic [1:0] CAUSE_WDT  = 2'b11;

   typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_TRAPPED} state_t;

   state_t          state, state_d;
   logic [1:0]      sync;
   logic [RW-1:0]   rst_cnt, rst_cnt_d;
   logic [WW-1:0]   wdt_cnt, wdt_cnt_d;
   logic [HW-1:0]   hold_cnt, hold_cnt_d;
   logic [BW-1:0]   blink_cnt, blink_cnt_d;
   logic            sys_reset_d, halted_d, led_d;
   logic [7:0]      trap_count_d;
   logic [1:0]      last_cause_d;

   // State register, counters and registered outputs; button reset is async
   always_ff @(posedge clk or posedge power_on_reset) begin
      if (power_on_reset) begin
         state      <= ST_RESET;
         sync       <= 2'b00;
         rst_cnt    <= '0;
         wdt_cnt    <= '0;
         hold_cnt   <= '0;
         blink_cnt  <= '0;
         sys_reset  <= 1'b1;
         halted     <= 1'b0;
         status_led <= 1'b0;
         trap_count <= 8'd0;
         last_cause <= CAUSE_POR;
      end else begin
         state      <= state_d;
         sync       <= {sync[0], 1'b1};
         rst_cnt    <= rst_cnt_d;
         wdt_cnt    <= wdt_cnt_d;
         hold_cnt   <= hold_cnt_d;
         blink_cnt  <= blink_cnt_d;
         sys_reset  <= sys_reset_d;
         halted     <= halted_d;
         status_led <= led_d;
         trap_count <= trap_count_d;
         last_cause <= last_cause_d;
      end
   end

   // Next state, counter updates and next output values
   always_comb begin
      state_d      = state;
      rst_cnt_d    = rst_cnt;
      wdt_cnt_d    = wdt_cnt;
      hold_cnt_d   = hold_cnt;
      blink_cnt_d  = blink_cnt;
      led_d        = status_led;
      trap_count_d = trap_count;
      last_cause_d = last_cause;

      case (state)
         ST_RESET: begin
            // internal re-entries find sync already at 1, so only the
            // power-on path pays the two synchroniser cycles
            if (sync[1]) begin
               if (rst_cnt == RST_LAST) state_d = ST_RUN;
               else                     rst_cnt_d = rst_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            // trap outranks expiry; a kick in the expiry cycle cancels it
            if (trap) begin
               state_d      = ST_TRAPPED;
               last_cause_d = CAUSE_TRAP;
               if (trap_count != 8'hff) trap_count_d = trap_count + 8'd1;
            end else if (wdt_kick) begin
               wdt_cnt_d = '0;
            end else if (WDT_EN) begin
               if (wdt_cnt == WDT_LAST) begin
                  state_d      = ST_RESET;
                  last_cause_d = CAUSE_WDT;
               end else begin
                  wdt_cnt_d = wdt_cnt + 1'b1;
               end
            end
         end
         ST_TRAPPED: begin
            if (blink_cnt == BLINK_LAST) begin
               blink_cnt_d = '0;
               led_d       = ~status_led;
            end else begin
               blink_cnt_d = blink_cnt + 1'b1;
            end
            // hold counter parks at its last value when auto-restart is off
            if (hold_cnt == HOLD_LAST) begin
               if (AUTO_EN) state_d = ST_RESET;
            end else begin
               hold_cnt_d = hold_cnt + 1'b1;
            end
         end
         default: state_d = ST_RESET;
      endcase

      // every state entry starts all counters from zero
      if (state_d != state) begin
         rst_cnt_d   = '0;
         wdt_cnt_d   = '0;
         hold_cnt_d  = '0;
         blink_cnt_d = '0;
      end

      sys_reset_d = (state_d == ST_RESET);
      halted_d    = (state_d == ST_TRAPPED);
      case (state_d)
         ST_RESET:   led_d = 1'b0;
         ST_RUN:     led_d = 1'b1;
         ST_TRAPPED: if (state != ST_TRAPPED) led_d = 1'b1;
         default:    led_d = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_reset_supervisor.sv
// Directed bench for reset_supervisor: a step table for reset release and
// trap/auto-restart, plus hand sequences for watchdog, trap priority with
// auto-restart off, trap_count saturation and asynchronous reset.
module tb_reset_supervisor;

   logic       clk = 1'b0;
   logic       por = 1'b0, trap = 1'b0, kick = 1'b0;
   logic       por_b = 1'b0, trap_b = 1'b0, kick_b = 1'b0;
   logic       sr, hlt, led;
   logic [7:0] cnt;
   logic [1:0] cause;
   logic       sr_b, hlt_b, led_b;
   logic [7:0] cnt_b;
   logic [1:0] cause_b;

   int nvec = 0;
   int nbad = 0;

   always #5 clk = ~clk;

   reset_supervisor #(
      .RESET_CYCLES(4), .WDT_CYCLES(10), .TRAP_HOLD(8),
      .AUTORESTART(1), .BLINK_CYCLES(2)
   ) dut (
      .clk(clk), .power_on_reset(por), .trap(trap), .wdt_kick(kick),
      .sys_reset(sr), .halted(hlt), .status_led(led),
      .trap_count(cnt), .last_cause(cause)
   );

   reset_supervisor #(
      .RESET_CYCLES(4), .WDT_CYCLES(10), .TRAP_HOLD(8),
      .AUTORESTART(0), .BLINK_CYCLES(2)
   ) dut_b (
      .clk(clk), .power_on_reset(por_b), .trap(trap_b), .wdt_kick(kick_b),
      .sys_reset(sr_b), .halted(hlt_b), .status_led(led_b),
      .trap_count(cnt_b), .last_cause(cause_b)
   );

   typedef struct {
      logic       trap;
      logic       kick;
      logic       sys_reset;
      logic       halted;
      logic       led;
      logic [7:0] count;
      logic [1:0] cause;
   } vec_t;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nbad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input logic t, input logic k);
      trap = t;
      kick = k;
      @(posedge clk);
      #1;
      trap   = 1'b0;
      kick   = 1'b0;
      trap_b = 1'b0;
   endtask

   // packed view of A's outputs: {sys_reset, halted, led, count, cause}
   function automatic logic [15:0] outs_a();
      return {3'b000, sr, hlt, led, cnt, cause};
   endfunction

   function automatic logic [15:0] pack(input logic s, input logic h, input logic l,
                                        input logic [7:0] c, input logic [1:0] ca);
      return {3'b000, s, h, l, c, ca};
   endfunction

   vec_t tbl[19];

   initial begin
      bit done;

      // edges counted from power_on_reset release
      for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'b01};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 2'b01};  // 6th edge: RUN
      tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 2'b10};  // trap -> TRAPPED
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 2'b10};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10};  // trap ignored
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 2'b10};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1, 2'b10};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1, 2'b10};
      for (int i = 14; i < 18; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'b10};
      tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 2'b10};  // restart done

      // async reset before any clock edge
      #2;
      por   = 1'b1;
      por_b = 1'b1;
      #1;
      chk("por_async_state", outs_a(), pack(1'b1, 1'b0, 1'b0, 8'd0, 2'b01));
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0);
      chk("por_held_state", outs_a(), pack(1'b1, 1'b0, 1'b0, 8'd0, 2'b01));
      por = 1'b0;

      for (int i = 0; i < 19; i++) begin
         tick(tbl[i].trap, tbl[i].kick);
         chk($sformatf("vec%0d", i), outs_a(),
             pack(tbl[i].sys_reset, tbl[i].halted, tbl[i].led, tbl[i].count, tbl[i].cause));
      end

      // watchdog kept alive by kicks every 9 clocks
      for (int i = 1; i <= 54; i++) begin
         tick(1'b0, (i % 9) == 0);
         chk($sformatf("wdt_alive%0d", i), {15'd0, sr}, 16'd0);
      end
      // stop kicking: expiry 10 clocks after the last kick, held 4 clocks
      for (int j = 1; j <= 14; j++) begin
         tick(1'b0, 1'b0);
         if (j < 10)       chk($sformatf("wdt_wait%0d", j), {15'd0, sr}, 16'd0);
         else if (j < 14)  chk($sformatf("wdt_rst%0d", j), {14'd0, sr, hlt}, 16'b10);
         else              chk("wdt_release", outs_a(), pack(1'b0, 1'b0, 1'b1, 8'd1, 2'b11));
      end
      chk("wdt_cause", {14'd0, cause}, 16'd3);
      // kick exactly in the expiry cycle
      for (int j = 0; j < 9; j++) tick(1'b0, 1'b0);
      tick(1'b0, 1'b1);
      chk("wdt_kick_expiry", {15'd0, sr}, 16'd0);
      for (int j = 0; j < 9; j++) tick(1'b0, 1'b0);
      chk("wdt_kick_restart", {15'd0, sr}, 16'd0);
      tick(1'b0, 1'b1);

      // trap in the expiry cycle, auto-restart off
      por_b = 1'b0;
      for (int j = 0; j < 6; j++) tick(1'b0, 1'b1);
      chk("b_run", {14'd0, sr_b, hlt_b}, 16'd0);
      for (int j = 0; j < 9; j++) tick(1'b0, 1'b1);
      trap_b = 1'b1;
      tick(1'b0, 1'b1);
      chk("b_trap_beats_wdt", pack(sr_b, hlt_b, led_b, cnt_b, cause_b),
          pack(1'b0, 1'b1, 1'b1, 8'd1, 2'b10));
      for (int j = 0; j < 1000; j++) tick(1'b0, 1'b1);
      chk("b_still_halted", {14'd0, sr_b, hlt_b}, 16'b01);

      // saturation: fresh power-on, then 256 traps
      por = 1'b1;
      tick(1'b0, 1'b0);
      por = 1'b0;
      for (int j = 0; j < 6; j++) tick(1'b0, 1'b0);
      chk("sat_run", {14'd0, sr, hlt}, 16'd0);
      for (int n = 1; n <= 256; n++) begin
         tick(1'b1, 1'b0);
         if (n == 1)   chk("sat_cnt1", {8'd0, cnt}, 16'd1);
         if (n == 255) chk("sat_cnt255", {8'd0, cnt}, 16'd255);
         if (n == 256) chk("sat_cnt256", {8'd0, cnt}, 16'd255);
         if (n < 256) begin
            done = 1'b0;
            for (int w = 0; w < 30 && !done; w++) begin
               tick(1'b0, 1'b0);
               if (!sr && !hlt) done = 1'b1;
            end
            if (!done) begin
               chk("sat_timeout", 16'd0, 16'd1);
               n = 257;
            end
         end
      end

      // async reset mid-TRAPPED, between clock edges
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      tick(1'b0, 1'b0);
      chk("mid_trapped", {15'd0, hlt}, 16'd1);
      #2;
      por = 1'b1;
      #1;
      chk("por_mid_trapped", outs_a(), pack(1'b1, 1'b0, 1'b0, 8'd0, 2'b01));
      tick(1'b0, 1'b0);
      por = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
